// File: rtl/ahb_pkg.sv
// Shared AHB encodings and burst helpers for the bus arbiter.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'd0,
    HBURST_INCR   = 3'd1,
    HBURST_WRAP4  = 3'd2,
    HBURST_INCR4  = 3'd3,
    HBURST_WRAP8  = 3'd4,
    HBURST_INCR8  = 3'd5,
    HBURST_WRAP16 = 3'd6,
    HBURST_INCR16 = 3'd7
  } hburst_e;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'b00,
    HRESP_ERROR = 2'b01,
    HRESP_RETRY = 2'b10,
    HRESP_SPLIT = 2'b11
  } hresp_e;

  localparam int BEAT_W = 4;

  // Remaining beats after the NONSEQ beat; undefined-length INCR counts as a single.
  function automatic logic [BEAT_W-1:0] burst_len(input logic [2:0] hburst);
    case (hburst)
      HBURST_WRAP4,  HBURST_INCR4:  burst_len = 4'd3;
      HBURST_WRAP8,  HBURST_INCR8:  burst_len = 4'd7;
      HBURST_WRAP16, HBURST_INCR16: burst_len = 4'd15;
      default:                      burst_len = 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/ahb_rr_pick.sv
// Rotating priority encoder: first eligible requester strictly after ptr, wrapping.
module ahb_rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  mask,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          valid
);

  logic [N-1:0]  elig;
  logic [IW-1:0] k;

  assign elig = req & ~mask;

  always_comb begin
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    k      = '0;
    // ptr itself is visited last, so it only wins when nobody else asks
    for (int i = 1; i <= N; i++) begin
      k = IW'((int'(ptr) + i) % N);
      if (!valid && elig[k]) begin
        valid = 1'b1;
        idx   = k;
      end
    end
    if (valid) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/ahb_rr_arbiter.sv
// AHB bus arbiter, fixed-priority or round-robin, burst and lock aware.
// Define AHB_ARB_SPLIT_EN to enable SPLIT masking driven by hsplit.
module ahb_rr_arbiter
  import ahb_pkg::*;
#(
  parameter  int NUM_MASTERS = 4,
  parameter  int DEF_MASTER  = 0,
  parameter  int RR_MODE     = 1,
  localparam int MW          = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                   hclk,
  input  logic                   hreset_n,
  input  logic [NUM_MASTERS-1:0] hbusreq,
  input  logic [NUM_MASTERS-1:0] hlock,
  input  logic [1:0]             htrans,
  input  logic [2:0]             hburst,
  input  logic                   hready,
  input  logic [1:0]             hresp,
  input  logic [15:0]            hsplit,
  output logic [NUM_MASTERS-1:0] hgrant,
  output logic [MW-1:0]          hmaster,
  output logic [MW-1:0]          hmaster_data,
  output logic                   hmastlock
);

  localparam logic [MW-1:0]          DEF_IDX    = MW'(DEF_MASTER);
  localparam logic [MW-1:0]          LAST_IDX   = MW'(NUM_MASTERS - 1);
  localparam logic [NUM_MASTERS-1:0] DEF_ONEHOT = NUM_MASTERS'(1) << DEF_MASTER;

  logic [BEAT_W-1:0]      beat_cnt;
  logic [MW-1:0]          grant_idx;
  logic [MW-1:0]          rr_ptr;
  logic [MW-1:0]          pick_ptr;
  logic [NUM_MASTERS-1:0] split_mask;
  logic [NUM_MASTERS-1:0] pick_onehot;
  logic [MW-1:0]          pick_idx;
  logic                   pick_valid;
  logic                   resp_err;
  logic                   err_first;
  logic                   lock_hold;
  logic                   arb_pt;
  logic                   unused_hsplit;

  assign unused_hsplit = ^hsplit;

  // A non-OKAY response drops any lock hold so the second response cycle can re-arbitrate.
  assign resp_err  = (hresp != HRESP_OKAY);
  assign err_first = !hready && resp_err;
  assign lock_hold = hmastlock && hlock[hmaster] && !resp_err;
  assign arb_pt    = hready && (beat_cnt <= BEAT_W'(1)) && !lock_hold;

  // Fixed priority is the rotating encoder parked on the last index.
  assign pick_ptr = (RR_MODE != 0) ? rr_ptr : LAST_IDX;

  ahb_rr_pick #(
    .N  (NUM_MASTERS),
    .IW (MW)
  ) u_pick (
    .req    (hbusreq),
    .mask   (split_mask),
    .ptr    (pick_ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .valid  (pick_valid)
  );

  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      beat_cnt <= '0;
    end else if (err_first) begin
      beat_cnt <= '0;
    end else if (hready) begin
      case (htrans)
        HTRANS_NONSEQ: beat_cnt <= burst_len(hburst);
        HTRANS_SEQ:    if (beat_cnt != '0) beat_cnt <= beat_cnt - BEAT_W'(1);
        default:       beat_cnt <= beat_cnt;
      endcase
    end
  end

  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      hgrant    <= DEF_ONEHOT;
      grant_idx <= DEF_IDX;
      rr_ptr    <= DEF_IDX;
    end else if (arb_pt) begin
      if (pick_valid) begin
        hgrant    <= pick_onehot;
        grant_idx <= pick_idx;
        rr_ptr    <= pick_idx;
      end else begin
        hgrant    <= DEF_ONEHOT;
        grant_idx <= DEF_IDX;
      end
    end
  end

  // Address phase follows the grant, data phase follows the address phase.
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      hmaster      <= DEF_IDX;
      hmaster_data <= DEF_IDX;
      hmastlock    <= 1'b0;
    end else if (hready) begin
      hmaster      <= grant_idx;
      hmaster_data <= hmaster;
      hmastlock    <= hlock[grant_idx];
    end
  end

`ifdef AHB_ARB_SPLIT_EN
  logic [NUM_MASTERS-1:0] split_set;
  logic [NUM_MASTERS-1:0] split_clr;

  always_comb begin
    split_set = '0;
    split_clr = hsplit[NUM_MASTERS-1:0];
    if (err_first && (hresp == HRESP_SPLIT) && (hmaster_data != DEF_IDX))
      split_set[hmaster_data] = 1'b1;
  end

  // Clear after set so a same-cycle resume wins.
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      split_mask <= '0;
    end else begin
      split_mask <= (split_mask | split_set) & ~split_clr;
    end
  end
`else
  assign split_mask = '0;
`endif

endmodule

// File: tb/tb_ahb_rr_arbiter.sv
// Bench for ahb_rr_arbiter: stimulus table plus hand-written burst, lock, retry, reset and split sequences.
module tb_ahb_rr_arbiter;
  import ahb_pkg::*;

  logic        hclk = 1'b0;
  logic        hreset_n;
  logic [3:0]  hbusreq;
  logic [3:0]  hlock;
  logic [1:0]  htrans;
  logic [2:0]  hburst;
  logic        hready;
  logic [1:0]  hresp;
  logic [15:0] hsplit;
  logic [3:0]  hgrant;
  logic [1:0]  hmaster;
  logic [1:0]  hmaster_data;
  logic        hmastlock;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  lock;
    logic [1:0]  trans;
    logic [2:0]  burst;
    logic        rdy;
    logic [1:0]  resp;
    logic [15:0] split;
    logic [3:0]  g;
    logic [1:0]  m;
    logic [1:0]  md;
    logic        lk;
  } vec_t;

  typedef struct {
    logic [3:0] g;
    logic [1:0] m;
    logic [1:0] md;
    logic       lk;
  } exp_t;

  exp_t sbq[$];
  vec_t tbl[11];

  ahb_rr_arbiter #(
    .NUM_MASTERS (4),
    .DEF_MASTER  (0),
    .RR_MODE     (1)
  ) dut (
    .hclk         (hclk),
    .hreset_n     (hreset_n),
    .hbusreq      (hbusreq),
    .hlock        (hlock),
    .htrans       (htrans),
    .hburst       (hburst),
    .hready       (hready),
    .hresp        (hresp),
    .hsplit       (hsplit),
    .hgrant       (hgrant),
    .hmaster      (hmaster),
    .hmaster_data (hmaster_data),
    .hmastlock    (hmastlock)
  );

  always #5 hclk = ~hclk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input logic [3:0] req, input logic [3:0] lock,
                              input logic [1:0] trans, input logic [2:0] burst,
                              input logic rdy, input logic [1:0] resp, input logic [15:0] split,
                              input logic [3:0] g, input logic [1:0] m, input logic [1:0] md,
                              input logic lk);
    vec_t v;
    v.req = req; v.lock = lock; v.trans = trans; v.burst = burst; v.rdy = rdy;
    v.resp = resp; v.split = split; v.g = g; v.m = m; v.md = md; v.lk = lk;
    return v;
  endfunction

  task automatic cmp(input string name, input string sig, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s %s: got %0h expected %0h", name, sig, act, exp);
    end
  endtask

  task automatic check_out(input string name);
    exp_t e;
    if (sbq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty, got hgrant %0h expected an entry", name, hgrant);
      return;
    end
    e = sbq.pop_front();
    cmp(name, "hgrant",       32'(hgrant),       32'(e.g));
    cmp(name, "hmaster",      32'(hmaster),      32'(e.m));
    cmp(name, "hmaster_data", 32'(hmaster_data), 32'(e.md));
    cmp(name, "hmastlock",    32'(hmastlock),    32'(e.lk));
  endtask

  task automatic apply(input vec_t v, input string name);
    exp_t e;
    hbusreq = v.req; hlock = v.lock; htrans = v.trans; hburst = v.burst;
    hready = v.rdy; hresp = v.resp; hsplit = v.split;
    e.g = v.g; e.m = v.m; e.md = v.md; e.lk = v.lk;
    sbq.push_back(e);
    @(posedge hclk);
    #1;
    check_out(name);
  endtask

  task automatic idle_inputs();
    hbusreq = 4'b0000; hlock = 4'b0000; htrans = HTRANS_IDLE; hburst = HBURST_SINGLE;
    hready = 1'b1; hresp = HRESP_OKAY; hsplit = 16'h0;
  endtask

  task automatic check_reset(input string name);
    cmp(name, "hgrant",       32'(hgrant),       32'h1);
    cmp(name, "hmaster",      32'(hmaster),      32'h0);
    cmp(name, "hmaster_data", 32'(hmaster_data), 32'h0);
    cmp(name, "hmastlock",    32'(hmastlock),    32'h0);
  endtask

  initial begin
    // Rotation with all masters requesting SINGLE transfers, then a 5-cycle stall.
    for (int i = 0; i < 5; i++) begin
      logic [3:0] g_exp [5];
      logic [1:0] m_exp [5];
      logic [1:0] d_exp [5];
      g_exp = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
      m_exp = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      d_exp = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3};
      tbl[i] = mk(4'b1111, 4'b0, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1, HRESP_OKAY, 16'h0,
                  g_exp[i], m_exp[i], d_exp[i], 1'b0);
    end
    tbl[5]  = mk(4'b0100, 4'b0, HTRANS_IDLE, HBURST_SINGLE, 1'b0, HRESP_OKAY, 16'h0, 4'b0010, 2'd0, 2'd3, 1'b0);
    tbl[6]  = mk(4'b1000, 4'b0, HTRANS_IDLE, HBURST_SINGLE, 1'b0, HRESP_OKAY, 16'h0, 4'b0010, 2'd0, 2'd3, 1'b0);
    tbl[7]  = mk(4'b0001, 4'b0, HTRANS_IDLE, HBURST_SINGLE, 1'b0, HRESP_OKAY, 16'h0, 4'b0010, 2'd0, 2'd3, 1'b0);
    tbl[8]  = mk(4'b0000, 4'b0, HTRANS_IDLE, HBURST_SINGLE, 1'b0, HRESP_OKAY, 16'h0, 4'b0010, 2'd0, 2'd3, 1'b0);
    tbl[9]  = mk(4'b1111, 4'b0, HTRANS_IDLE, HBURST_SINGLE, 1'b0, HRESP_OKAY, 16'h0, 4'b0010, 2'd0, 2'd3, 1'b0);
    tbl[10] = mk(4'b0000, 4'b0, HTRANS_IDLE, HBURST_SINGLE, 1'b1, HRESP_OKAY, 16'h0, 4'b0001, 2'd1, 2'd0, 1'b0);

    hreset_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge hclk);
    #1;
    check_reset("reset");
    @(negedge hclk);
    hreset_n = 1'b1;
    @(posedge hclk);
    #1;

    for (int i = 0; i < 11; i++) apply(tbl[i], $sformatf("tbl%0d", i));

    // Master 1 INCR8; master 2 asks at beat 2, owner drops its request mid-burst.
    apply(mk(4'b0010, 4'b0, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, HRESP_OKAY, 16'h0, 4'b0010, 2'd0, 2'd1, 1'b0), "incr8_grant");
    apply(mk(4'b0010, 4'b0, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, HRESP_OKAY, 16'h0, 4'b0010, 2'd1, 2'd0, 1'b0), "incr8_own");
    apply(mk(4'b0010, 4'b0, HTRANS_NONSEQ, HBURST_INCR8,  1'b1, HRESP_OKAY, 16'h0, 4'b0010, 2'd1, 2'd1, 1'b0), "incr8_b1");
    for (int b = 2; b <= 7; b++)
      apply(mk((b < 4) ? 4'b0110 : 4'b0100, 4'b0, HTRANS_SEQ, HBURST_INCR8, 1'b1, HRESP_OKAY, 16'h0,
               4'b0010, 2'd1, 2'd1, 1'b0), $sformatf("incr8_b%0d", b));
    apply(mk(4'b0100, 4'b0, HTRANS_SEQ,    HBURST_INCR8,  1'b1, HRESP_OKAY, 16'h0, 4'b0100, 2'd1, 2'd1, 1'b0), "incr8_b8");
    apply(mk(4'b0100, 4'b0, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, HRESP_OKAY, 16'h0, 4'b0100, 2'd2, 2'd1, 1'b0), "incr8_after");

    // Locked INCR from master 3 holds the bus against master 0.
    apply(mk(4'b1000, 4'b1000, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, HRESP_OKAY, 16'h0, 4'b1000, 2'd2, 2'd2, 1'b0), "lock_grant");
    apply(mk(4'b1000, 4'b1000, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, HRESP_OKAY, 16'h0, 4'b1000, 2'd3, 2'd2, 1'b1), "lock_own");
    apply(mk(4'b1001, 4'b1000, HTRANS_NONSEQ, HBURST_INCR,   1'b1, HRESP_OKAY, 16'h0, 4'b1000, 2'd3, 2'd3, 1'b1), "lock_hold1");
    apply(mk(4'b1001, 4'b1000, HTRANS_SEQ,    HBURST_INCR,   1'b1, HRESP_OKAY, 16'h0, 4'b1000, 2'd3, 2'd3, 1'b1), "lock_hold2");
    apply(mk(4'b0001, 4'b0000, HTRANS_SEQ,    HBURST_INCR,   1'b1, HRESP_OKAY, 16'h0, 4'b0001, 2'd3, 2'd3, 1'b0), "lock_release");

    // RETRY mid INCR16 clears the beat counter so the next ready cycle re-arbitrates.
    apply(mk(4'b0001, 4'b0, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, HRESP_OKAY,  16'h0, 4'b0001, 2'd0, 2'd3, 1'b0), "retry_own");
    apply(mk(4'b0001, 4'b0, HTRANS_NONSEQ, HBURST_INCR16, 1'b1, HRESP_OKAY,  16'h0, 4'b0001, 2'd0, 2'd0, 1'b0), "retry_b1");
    apply(mk(4'b0011, 4'b0, HTRANS_SEQ,    HBURST_INCR16, 1'b1, HRESP_OKAY,  16'h0, 4'b0001, 2'd0, 2'd0, 1'b0), "retry_b2");
    apply(mk(4'b0011, 4'b0, HTRANS_SEQ,    HBURST_INCR16, 1'b0, HRESP_RETRY, 16'h0, 4'b0001, 2'd0, 2'd0, 1'b0), "retry_c1");
    apply(mk(4'b0011, 4'b0, HTRANS_IDLE,   HBURST_INCR16, 1'b1, HRESP_RETRY, 16'h0, 4'b0010, 2'd0, 2'd0, 1'b0), "retry_c2");

    // Asynchronous reset in the middle of an INCR4 burst.
    apply(mk(4'b0010, 4'b0, HTRANS_NONSEQ, HBURST_INCR4, 1'b1, HRESP_OKAY, 16'h0, 4'b0010, 2'd1, 2'd0, 1'b0), "rst_burst");
    idle_inputs();
    hreset_n = 1'b0;
    #2;
    check_reset("rst_mid");
    @(negedge hclk);
    hreset_n = 1'b1;
    @(posedge hclk);
    #1;
    apply(mk(4'b0010, 4'b0, HTRANS_IDLE, HBURST_SINGLE, 1'b1, HRESP_OKAY, 16'h0, 4'b0010, 2'd0, 2'd0, 1'b0), "rst_after");

`ifdef AHB_ARB_SPLIT_EN
    // SPLIT on master 2 masks it until hsplit[2] resumes it.
    apply(mk(4'b0100, 4'b0, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, HRESP_OKAY,  16'h0,    4'b0100, 2'd1, 2'd0, 1'b0), "split_grant");
    apply(mk(4'b0100, 4'b0, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, HRESP_OKAY,  16'h0,    4'b0100, 2'd2, 2'd1, 1'b0), "split_own");
    apply(mk(4'b0100, 4'b0, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1, HRESP_OKAY,  16'h0,    4'b0100, 2'd2, 2'd2, 1'b0), "split_addr");
    apply(mk(4'b0100, 4'b0, HTRANS_IDLE,   HBURST_SINGLE, 1'b0, HRESP_SPLIT, 16'h0,    4'b0100, 2'd2, 2'd2, 1'b0), "split_c1");
    apply(mk(4'b0100, 4'b0, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, HRESP_SPLIT, 16'h0,    4'b0001, 2'd2, 2'd2, 1'b0), "split_c2");
    apply(mk(4'b0100, 4'b0, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, HRESP_OKAY,  16'h0,    4'b0001, 2'd0, 2'd2, 1'b0), "split_masked");
    apply(mk(4'b0100, 4'b0, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, HRESP_OKAY,  16'h0004, 4'b0001, 2'd0, 2'd0, 1'b0), "split_resume");
    apply(mk(4'b0100, 4'b0, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, HRESP_OKAY,  16'h0,    4'b0100, 2'd0, 2'd0, 1'b0), "split_regrant");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
